// File: rtl/serial_subtractor_pe_pkg.sv
// Shared PE package: state encoding and default datapath width.
//   PE_WIDTH   default operand width, reused by the adder PEs
//   pe_state_e IDLE / SHIFT / DONE encoding for the serial PEs
package serial_subtractor_pe_pkg;

   localparam int unsigned PE_WIDTH = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_DONE  = 2'b10
   } pe_state_e;

endpackage

// File: rtl/full_subtractor_structural.sv
// Gate-level one-bit full subtractor: diff = din1 - din2 - bin.
//   din1  minuend bit
//   din2  subtrahend bit
//   bin   borrow in
//   diff  difference bit
//   bout  borrow out
module full_subtractor_structural (
   input  logic din1,
   input  logic din2,
   input  logic bin,
   output logic diff,
   output logic bout
);

   logic x_ab;
   logic n_a;
   logic n_x;
   logic g_ab;
   logic g_bin;

   xor u_x1 (x_ab, din1, din2);
   xor u_x2 (diff, x_ab, bin);

   // borrow generated by this bit, or propagated when the bits are equal
   not u_n1 (n_a, din1);
   and u_a1 (g_ab, n_a, din2);
   not u_n2 (n_x, x_ab);
   and u_a2 (g_bin, n_x, bin);
   or  u_o1 (bout, g_ab, g_bin);

endmodule

// File: rtl/serial_subtractor_pe.sv
// Bit-serial unsigned subtractor PE: diff = din1 - din2, LSB-first, one bit
// per clock through a single full-subtractor cell.
//   clk, rst_n           clock, synchronous active-low reset
//   in_valid/in_ready    operand handshake (din1 minuend, din2 subtrahend)
//   out_valid/out_ready  result handshake
//   diff                 (din1 - din2) mod 2^WIDTH
//   borrow               1 iff din1 < din2
module serial_subtractor_pe
   import serial_subtractor_pe_pkg::*;
#(
   parameter int unsigned WIDTH = PE_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] din1,
   input  logic [WIDTH-1:0] din2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   pe_state_e        state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             brw_q, brw_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             ov_q;
   logic             fs_diff;
   logic             fs_bout;

   // single shared cell; operands are presented at bit 0 of the shifters
   full_subtractor_structural u_fs (
      .din1 (a_q[0]),
      .din2 (b_q[0]),
      .bin  (brw_q),
      .diff (fs_diff),
      .bout (fs_bout)
   );

   // in_ready is gated by rst_n so nothing is accepted while reset is held
   assign in_ready  = (state_q == ST_IDLE) && rst_n;
   assign out_valid = ov_q;
   assign diff      = res_q;
   assign borrow    = brw_q;

   // next-state and datapath update
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      brw_d   = brw_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid && in_ready) begin
               a_d     = din1;
               b_d     = din2;
               brw_d   = 1'b0;
               cnt_d   = '0;
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            a_d   = a_q >> 1;
            b_d   = b_q >> 1;
            res_d = res_q >> 1;
            res_d[WIDTH-1] = fs_diff;
            brw_d = fs_bout;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // state and datapath registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         brw_q   <= 1'b0;
         cnt_q   <= '0;
         ov_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         brw_q   <= brw_d;
         cnt_q   <= cnt_d;
         ov_q    <= (state_d == ST_DONE);
      end
   end

endmodule

// File: doc/serial_subtractor_pe.md
Name: serial_subtractor_pe

Overview:
Bit-serial unsigned subtractor processing element. It accepts two WIDTH-bit operands over a valid/ready handshake and computes din1 - din2 LSB-first, one bit per clock, through a single structural full-subtractor cell. It returns the difference and the final borrow over a second valid/ready handshake. It is the inverse-operation companion to the PE adder cells, for area-constrained PE arrays.

Parameters:
WIDTH, 8, operand/result width in bits; legal range WIDTH >= 1.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  reset, synchronous, active-low
in_valid  input  1  operands on din1/din2 are valid
in_ready  output  1  block can accept operands; equals (state==IDLE) && rst_n
din1  input  WIDTH  minuend, unsigned
din2  input  WIDTH  subtrahend, unsigned
out_valid  output  1  diff/borrow hold a completed result
out_ready  input  1  consumer accepts the result
diff  output  WIDTH  (din1 - din2) mod 2^WIDTH, registered
borrow  output  1  final borrow; 1 iff din1 < din2, registered

Behaviour:
- Single clock domain, all state on the rising clk edge.
- Reset: rst_n sampled low at an edge gives state=IDLE, out_valid=0, diff=0, borrow=0, operand shift registers=0, bit counter=0.
- in_ready is 0 while rst_n is low.
- Reset has priority over every other event, including mid-SHIFT or mid-DONE; an in-flight operation is discarded and no result is emitted.
- States are IDLE, SHIFT and DONE. One operation is in flight at most.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid && in_ready at edge k: capture din1 into shift register A and din2 into B, clear the borrow register, clear the counter, go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT (edges k+1 .. k+WIDTH):
  - Per edge, with a0=A[0], b0=B[0], bi=borrow register:
    - d = a0 ^ b0 ^ bi
    - bo = (~a0 & b0) | (~(a0 ^ b0) & bi)
  - Shift d into the MSB of the result register (result >> 1); shift A and B right by one; borrow register <= bo; counter++.
  - When the counter reaches WIDTH-1 at an edge, that is the last shift; the next state is DONE.
  - in_ready=0 and out_valid=0 throughout SHIFT.
- DONE:
  - out_valid=1. diff = result register, borrow = borrow register; both hold stable while out_ready=0.
  - On out_valid && out_ready at an edge, go to IDLE.
  - There is no same-cycle re-accept: in_ready=0 in DONE, so new operands are accepted at the earliest one cycle after the drain.
- Latency: out_valid is first high in the cycle after edge k+WIDTH, i.e. WIDTH cycles after the accept edge.
- Maximum throughput: one result per WIDTH+2 cycles.
- diff and borrow change only during SHIFT, and keep the last result in IDLE until the next operation starts. They are meaningful only while out_valid=1.
- Counter width is max(1, $clog2(WIDTH)). WIDTH=1 gives exactly one SHIFT cycle.
- in_valid and din1/din2 are ignored outside an accepting IDLE cycle. No requirement is placed on the upstream driver holding its values after the accept.
- Arithmetic: {borrow, diff} == {1'b0, din1} - {1'b0, din2} in two's-complement WIDTH+1 bits.

Decomposition:
- Shared PE package/header holds:
  - state encoding constants ST_IDLE=2'b00, ST_SHIFT=2'b01, ST_DONE=2'b10
  - the default WIDTH constant, reused by the adder PEs
- One sub-module: full_subtractor_structural. It is gate-primitive, with ports din1, din2, bin, diff, bout, and is instantiated once for the per-bit d/bo logic.
- The FSM, shift registers, counter and handshake stay in serial_subtractor_pe.

Test Plan:
1. WIDTH=8, din1=0x5A, din2=0x23, accepted at edge k -> out_valid rises after edge k+8; diff=0x37, borrow=0.
2. din1=0x00, din2=0x01 -> diff=0xFF, borrow=1. Then din1=0x80, din2=0x80 -> diff=0x00, borrow=0. Then din1=0xFF, din2=0x00 -> diff=0xFF, borrow=0.
3. Backpressure: result 0x37 ready, out_ready held 0 for 5 cycles while in_valid=1 with din1=0x10, din2=0x01 -> diff/borrow stable and in_ready=0 for all 5 cycles. After the drain edge, the 0x10/0x01 operands are accepted in the following IDLE cycle and give diff=0x0F.
4. Reset mid-op: start 0x5A-0x23, drive rst_n=0 for one edge after 4 shifts -> state IDLE, out_valid=0, diff=0x00, borrow=0, no result emitted. A following 0x05-0x07 gives diff=0xFE, borrow=1.
5. Reset behaviour: rst_n low with in_valid=1 -> in_ready=0 and no capture; the first IDLE cycle after release has in_ready=1.
6. 1000 random back-to-back vectors with random out_ready, for WIDTH=8 and for a WIDTH=1 build -> every result matches {1'b0,din1}-{1'b0,din2}; result count equals accept count; accept-to-out_valid gap is exactly WIDTH cycles.
